// File: rtl/sc_random_pkg.sv
// Shared definitions for the random row loader: FSM state encoding and the
// default fallback row pattern.
package sc_random_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Centre two columns lit: always a legal, sparse row.
    localparam logic [7:0] FALLBACK_ROW_DEFAULT = 8'b00011000;

endpackage

// File: rtl/sc_random_row_loader_if.sv
// Row loader bus: random generator input, request/ack handshake and the
// delivered row towards the game/matrix datapath.
interface sc_random_row_loader_if #(
    parameter int DATAWIDTH = 8
);
    logic [DATAWIDTH-1:0] random_data_InBUS;
    logic                 row_req_In;
    logic                 row_ack_In;
    logic [DATAWIDTH-1:0] row_data_OutBUS;
    logic                 row_valid_Out;
    logic                 row_fallback_Out;
    logic [7:0]           row_count_OutBUS;

    // Loader side.
    modport master (
        input  random_data_InBUS,
        input  row_req_In,
        input  row_ack_In,
        output row_data_OutBUS,
        output row_valid_Out,
        output row_fallback_Out,
        output row_count_OutBUS
    );

    // Consumer / environment side.
    modport slave (
        output random_data_InBUS,
        output row_req_In,
        output row_ack_In,
        input  row_data_OutBUS,
        input  row_valid_Out,
        input  row_fallback_Out,
        input  row_count_OutBUS
    );
endinterface

// File: rtl/sc_random_popcount.sv
// Combinational ones counter, width-parameterised for density checks.
module sc_random_popcount #(
    parameter int DATAWIDTH = 8,
    parameter int CNT_W     = $clog2(DATAWIDTH + 1)
) (
    input  logic [DATAWIDTH-1:0] data,
    output logic [CNT_W-1:0]     ones
);

    // Sum every bit of the input word.
    always_comb begin
        ones = '0;
        for (int i = 0; i < DATAWIDTH; i++) begin
            ones = ones + CNT_W'(data[i]);
        end
    end

endmodule

// File: rtl/sc_random_row_loader.sv
// Samples the free-running random byte on request, filters it by ones
// density, and hands the accepted row out over a valid/ack handshake.
// After RETRY_MAX consecutive rejections a fixed fallback row is emitted so
// a request always completes.
module sc_random_row_loader
    import sc_random_pkg::*;
#(
    parameter int                   DATAWIDTH    = 8,
    parameter int                   MIN_ONES     = 1,
    parameter int                   MAX_ONES     = 5,
    parameter int                   RETRY_MAX    = 4,
    parameter logic [DATAWIDTH-1:0] FALLBACK_ROW = DATAWIDTH'(FALLBACK_ROW_DEFAULT)
) (
    input  logic                  SC_RANDOM_CLOCK_50,
    input  logic                  SC_RANDOM_RESET_InHigh,
    sc_random_row_loader_if.master bus
);

    localparam int CNT_W   = $clog2(DATAWIDTH + 1);
    localparam int RETRY_W = $clog2(RETRY_MAX + 1);

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     ones;
    logic [RETRY_W-1:0]   retry;
    logic                 accept;
    logic                 last_try;

    logic                 retry_clr;
    logic                 retry_inc;
    logic                 load_row;
    logic                 load_fallback;
    logic                 take_ack;

    logic [DATAWIDTH-1:0] row_data;
    logic                 row_valid;
    logic                 row_fallback;
    logic [7:0]           row_count;

    sc_random_popcount #(
        .DATAWIDTH (DATAWIDTH),
        .CNT_W     (CNT_W)
    ) u_popcount (
        .data (bus.random_data_InBUS),
        .ones (ones)
    );

    assign accept   = (ones >= CNT_W'(MIN_ONES)) && (ones <= CNT_W'(MAX_ONES));
    assign last_try = (retry == RETRY_W'(RETRY_MAX - 1));

    // State register.
    always_ff @(posedge SC_RANDOM_CLOCK_50 or posedge SC_RANDOM_RESET_InHigh) begin
        if (SC_RANDOM_RESET_InHigh) state <= IDLE;
        else                        state <= state_next;
    end

    // Next-state decode; a rejected byte keeps us in SAMPLE so the next,
    // already-advanced generator byte is tried on the following cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.row_req_In) state_next = SAMPLE;
            SAMPLE:  if (accept || last_try) state_next = HOLD;
            HOLD:    if (bus.row_ack_In) state_next = bus.row_req_In ? SAMPLE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-state control strobes for the retry counter and output registers.
    always_comb begin
        retry_clr     = 1'b0;
        retry_inc     = 1'b0;
        load_row      = 1'b0;
        load_fallback = 1'b0;
        take_ack      = 1'b0;
        case (state)
            IDLE: retry_clr = bus.row_req_In;
            SAMPLE: begin
                if (accept)        load_row      = 1'b1;
                else if (last_try) load_fallback = 1'b1;
                else               retry_inc     = 1'b1;
            end
            HOLD: begin
                // Clearing on every ack gives a back-to-back row a fresh budget.
                if (bus.row_ack_In) begin
                    take_ack  = 1'b1;
                    retry_clr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Consecutive-rejection counter for the current request.
    always_ff @(posedge SC_RANDOM_CLOCK_50 or posedge SC_RANDOM_RESET_InHigh) begin
        if (SC_RANDOM_RESET_InHigh) retry <= '0;
        else if (retry_clr)         retry <= '0;
        else if (retry_inc)         retry <= retry + RETRY_W'(1);
    end

    // Output row registers and delivered-row counter; row_data keeps its
    // last value after the ack.
    always_ff @(posedge SC_RANDOM_CLOCK_50 or posedge SC_RANDOM_RESET_InHigh) begin
        if (SC_RANDOM_RESET_InHigh) begin
            row_data     <= '0;
            row_valid    <= 1'b0;
            row_fallback <= 1'b0;
            row_count    <= '0;
        end else if (load_row) begin
            row_data     <= bus.random_data_InBUS;
            row_valid    <= 1'b1;
            row_fallback <= 1'b0;
        end else if (load_fallback) begin
            row_data     <= FALLBACK_ROW;
            row_valid    <= 1'b1;
            row_fallback <= 1'b1;
        end else if (take_ack) begin
            row_valid    <= 1'b0;
            row_fallback <= 1'b0;
            row_count    <= row_count + 8'd1;
        end
    end

    assign bus.row_data_OutBUS  = row_data;
    assign bus.row_valid_Out    = row_valid;
    assign bus.row_fallback_Out = row_fallback;
    assign bus.row_count_OutBUS = row_count;

endmodule

// File: tb/tb_sc_random_row_loader.sv
// Bench for sc_random_row_loader: directed scenarios plus randomized rows
// checked against a transaction-level model of the density/retry rules.
module tb_sc_random_row_loader;

    localparam int         MIN_ONES  = 1;
    localparam int         MAX_ONES  = 5;
    localparam int         RETRY_MAX = 4;
    localparam logic [7:0] FB_ROW    = 8'h18;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #10 clk = ~clk;

    sc_random_row_loader_if #(.DATAWIDTH(8)) bus ();

    sc_random_row_loader dut (
        .SC_RANDOM_CLOCK_50     (clk),
        .SC_RANDOM_RESET_InHigh (rst),
        .bus                    (bus)
    );

    int         n_checks  = 0;
    int         n_errors  = 0;
    int         exp_count = 0;
    logic [7:0] exp_data  = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit dense_ok(input logic [7:0] b);
        int c;
        c = $countones(b);
        return (c >= MIN_ONES) && (c <= MAX_ONES);
    endfunction

    // Biased toward rejected bytes so retries and fallbacks occur often.
    function automatic logic [7:0] rand_byte();
        logic [7:0] b;
        case ($urandom_range(5, 0))
            0:       b = 8'h00;
            1:       b = 8'hFF;
            2:       b = 8'hFE;
            3:       b = 8'h3F;
            default: b = 8'($urandom);
        endcase
        return b;
    endfunction

    task automatic check_outputs(input string tag, input logic v, input logic [7:0] d, input logic f);
        check({tag, ".valid"},    32'(bus.row_valid_Out),    32'(v));
        check({tag, ".data"},     32'(bus.row_data_OutBUS),  32'(d));
        check({tag, ".fallback"}, 32'(bus.row_fallback_Out), 32'(f));
        check({tag, ".count"},    32'(bus.row_count_OutBUS), 32'(exp_count[7:0]));
    endtask

    // One complete row transaction. The model picks the first acceptable
    // byte among the first RETRY_MAX sampled bytes, else the fallback row.
    task automatic run_row(input logic [7:0] seq [RETRY_MAX], input bit from_idle,
                           input int hold_cycles, input bit next_req);
        int k;
        bit fb;
        k = -1;
        for (int i = 0; i < RETRY_MAX; i++)
            if (k < 0 && dense_ok(seq[i])) k = i;
        fb = (k < 0);
        if (fb) k = RETRY_MAX - 1;

        if (from_idle) begin
            bus.row_req_In        = 1'b1;
            bus.row_ack_In        = 1'b0;
            bus.random_data_InBUS = 8'($urandom);
            step();
            check_outputs("enter", 1'b0, exp_data, 1'b0);
        end
        // Request may drop during sampling without aborting.
        bus.row_req_In = 1'($urandom_range(1, 0));
        for (int i = 0; i <= k; i++) begin
            bus.random_data_InBUS = seq[i];
            bus.row_ack_In        = 1'($urandom_range(1, 0));
            step();
            if (i < k) check_outputs("sample", 1'b0, exp_data, 1'b0);
        end
        bus.row_ack_In = 1'b0;
        exp_data = fb ? FB_ROW : seq[k];
        check_outputs("deliver", 1'b1, exp_data, fb);
        for (int h = 0; h < hold_cycles; h++) begin
            bus.random_data_InBUS = 8'($urandom);
            step();
            check_outputs("hold", 1'b1, exp_data, fb);
        end
        bus.row_ack_In = 1'b1;
        bus.row_req_In = next_req;
        step();
        exp_count = (exp_count + 1) % 256;
        bus.row_ack_In = 1'b0;
        check_outputs("ack", 1'b0, exp_data, 1'b0);
    endtask

    logic [7:0] seq [RETRY_MAX];
    bit         prev_req;

    initial begin
        bus.random_data_InBUS = 8'h00;
        bus.row_req_In        = 1'b0;
        bus.row_ack_In        = 1'b0;
        #1;
        check_outputs("reset_init", 1'b0, 8'h00, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        check_outputs("post_reset", 1'b0, 8'h00, 1'b0);

        // Single accepted row, first byte popcount 3.
        seq = '{8'h25, 8'h00, 8'h00, 8'h00};
        run_row(seq, 1'b1, 2, 1'b0);
        check("t2.count", 32'(bus.row_count_OutBUS), 32'd1);

        // Ack pulsed while idle is ignored.
        bus.row_ack_In = 1'b1;
        step();
        step();
        bus.row_ack_In = 1'b0;
        step();
        check_outputs("idle_ack", 1'b0, exp_data, 1'b0);

        // Two rejections (popcount 7, 8) then accept.
        seq = '{8'hFE, 8'hFF, 8'h81, 8'h00};
        run_row(seq, 1'b1, 1, 1'b0);

        // All rejected: fallback row.
        seq = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_row(seq, 1'b1, 1, 1'b0);

        // Back-to-back: ack with req held, next row from 8'h03.
        seq = '{8'h25, 8'h00, 8'h00, 8'h00};
        run_row(seq, 1'b1, 0, 1'b1);
        seq = '{8'h03, 8'h00, 8'h00, 8'h00};
        run_row(seq, 1'b0, 0, 1'b0);

        // Asynchronous reset in the middle of HOLD with row 8'h25 valid.
        bus.row_req_In = 1'b1;
        step();
        bus.row_req_In        = 1'b0;
        bus.random_data_InBUS = 8'h25;
        step();
        check_outputs("pre_reset_hold", 1'b1, 8'h25, 1'b0);
        #3 rst = 1'b1;
        #1;
        exp_count = 0;
        exp_data  = 8'h00;
        check_outputs("async_reset", 1'b0, 8'h00, 1'b0);
        step();
        rst = 1'b0;
        bus.row_ack_In = 1'b1;
        step();
        bus.row_ack_In = 1'b0;
        check_outputs("after_reset", 1'b0, 8'h00, 1'b0);
        seq = '{8'h0F, 8'h00, 8'h00, 8'h00};
        run_row(seq, 1'b1, 0, 1'b0);

        // Randomized rows, mixing idle starts and back-to-back; enough to
        // wrap the delivered-row counter.
        prev_req = 1'b0;
        for (int r = 0; r < 270; r++) begin
            bit nr;
            for (int i = 0; i < RETRY_MAX; i++) seq[i] = rand_byte();
            nr = (r == 269) ? 1'b0 : 1'($urandom_range(3, 0) != 0);
            run_row(seq, !prev_req, int'($urandom_range(2, 0)), nr);
            if (exp_count == 0)
                check("wrap.count", 32'(bus.row_count_OutBUS), 32'd0);
            prev_req = nr;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
